// File: rtl/cache_parameters.sv
// Shared cache/memory types: block geometry, memory port request/response, arbiter states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_parameters;

  localparam int ADDR_WIDTH = 32;
  localparam int WORD_WIDTH = 32;
  localparam int BLOCK_SIZE = 4;

  // One cache block, word 0 in the least significant position.
  typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_t;

  // Cache -> main memory request side.
  typedef struct packed {
    logic                  cs;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    block_t                data;
  } memory_request_t;

  // Main memory -> cache response side.
  typedef struct packed {
    logic   ack;
    block_t data;
  } memory_response_t;

  // Memory port arbiter states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted req scanning last_idx+1, last_idx+2, ... modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; vld is low when no request is asserted.
module rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_idx,
  output logic                       vld,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int          IDX_W = $clog2(NUM_REQ);
  localparam int unsigned NUM_U = NUM_REQ;

  // (base + off) mod NUM_REQ; off never exceeds NUM_REQ so one wrap is enough,
  // and no power-of-two request count is assumed.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_U) sum = sum - NUM_U;
    return IDX_W'(sum);
  endfunction

  // Scan from the farthest candidate back to the nearest so the nearest asserted one wins.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int unsigned i = NUM_U; i >= 1; i--) begin
      if (req[wrap_add(last_idx, i)]) begin
        vld = 1'b1;
        idx = wrap_add(last_idx, i);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one cache-to-memory block port among NUM_REQ caches.
// Latency: rq_cs seen in IDLE at t -> mrq_cs at t+1; rs_ack same cycle as mrs_ack; next mrq_cs at ack+3.
// Backpressure: requests are levels held until rs_ack; memory stalls the winner by withholding mrs_ack.
module mem_port_arbiter
  import cache_parameters::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   rq_addr,
  input  logic [NUM_REQ-1:0]                   rq_cs,
  input  logic [NUM_REQ-1:0]                   rq_rw,
  input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][WORD_WIDTH-1:0] rq_data,
  output logic [NUM_REQ-1:0]                   rs_ack,
  output logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] rs_data,
  output logic [ADDR_WIDTH-1:0]                mrq_addr,
  output logic                                 mrq_cs,
  output logic                                 mrq_rw,
  output logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] mrq_data,
  input  logic                                 mrs_ack,
  input  logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] mrs_data,
  output logic [$clog2(NUM_REQ)-1:0]           gnt_id,
  output logic                                 busy,
  output logic                                 err_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // A zero timeout disables the watchdog; keep the counter at least one bit wide.
  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  // Last grant resets to the top index so requester 0 is first in line.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] last_gnt_q, last_gnt_d;
  memory_request_t  mrq_q, mrq_d;
  memory_response_t mrs;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;

  assign mrs.ack  = mrs_ack;
  assign mrs.data = mrs_data;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req      (rq_cs),
    .last_idx (last_gnt_q),
    .vld      (pick_vld),
    .idx      (pick_idx)
  );

  // Arbitration FSM: capture the winner in IDLE, hold the request through BUSY,
  // then force one cs-low RELEASE cycle so the acked cache can drop its request.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    mrq_d      = mrq_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = BUSY;
          last_gnt_d = pick_idx;
          mrq_d.cs   = 1'b1;
          mrq_d.rw   = rq_rw[pick_idx];
          mrq_d.addr = rq_addr[pick_idx];
          mrq_d.data = rq_data[pick_idx];
        end
      end
      BUSY: begin
        if (mrs.ack) begin
          state_d  = RELEASE;
          mrq_d.cs = 1'b0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mrq_d.cs = 1'b0;
      end
    endcase
  end

  // Watchdog: count un-acked BUSY cycles from each grant, saturating; the error is sticky.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    if (TIMEOUT_CYCLES != 0) begin
      if (state_q == IDLE && pick_vld) begin
        wait_cnt_d = '0;
      end else if (state_q == BUSY && !mrs.ack && wait_cnt_q != CNT_MAX) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if (state_q == BUSY && wait_cnt_d == CNT_MAX) begin
        err_d = 1'b1;
      end
    end
  end

  // Completion pulse goes only to the current grantee, and only while a transaction is open.
  always_comb begin
    rs_ack = '0;
    if (state_q == BUSY && mrs.ack) begin
      rs_ack[last_gnt_q] = 1'b1;
    end
  end

  // State registers; reset abandons any open transaction without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= LAST_RST;
      mrq_q      <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      mrq_q      <= mrq_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign rs_data     = mrs.data;
  assign mrq_cs      = mrq_q.cs;
  assign mrq_rw      = mrq_q.rw;
  assign mrq_addr    = mrq_q.addr;
  assign mrq_data    = mrq_q.data;
  assign gnt_id      = last_gnt_q;
  assign busy        = (state_q == BUSY);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a per-cycle reference model.
// Latency: n/a.
// Backpressure: a bench memory acks a fixed number of cycles after mrq_cs rises, or never.
module tb_mem_port_arbiter;
  import cache_parameters::*;

  localparam int NR = 2;
  localparam int TO = 8;

  logic                             clk = 1'b0;
  logic                             rst;
  logic [NR-1:0][ADDR_WIDTH-1:0]    rq_addr;
  logic [NR-1:0]                    rq_cs;
  logic [NR-1:0]                    rq_rw;
  logic [NR-1:0][BLOCK_SIZE-1:0][WORD_WIDTH-1:0] rq_data;
  logic [NR-1:0]                    rs_ack;
  block_t                           rs_data;
  logic [ADDR_WIDTH-1:0]            mrq_addr;
  logic                             mrq_cs;
  logic                             mrq_rw;
  block_t                           mrq_data;
  logic                             mrs_ack;
  block_t                           mrs_data;
  logic [$clog2(NR)-1:0]            gnt_id;
  logic                             busy;
  logic                             err_timeout;

  mem_port_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rq_addr     (rq_addr),
    .rq_cs       (rq_cs),
    .rq_rw       (rq_rw),
    .rq_data     (rq_data),
    .rs_ack      (rs_ack),
    .rs_data     (rs_data),
    .mrq_addr    (mrq_addr),
    .mrq_cs      (mrq_cs),
    .mrq_rw      (mrq_rw),
    .mrq_data    (mrq_data),
    .mrs_ack     (mrs_ack),
    .mrs_data    (mrs_data),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // All stimulus and literal checks happen 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int max_cyc, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < max_cyc) begin
      if (rs_ack != '0) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  // ---------------- bench memory ----------------
  bit mem_en  = 1'b1;
  int mem_lat = 3;
  bit stray   = 1'b0;
  int bcnt    = 0;

  initial begin
    mrs_ack  = 1'b0;
    mrs_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    forever begin
      @(posedge clk);
      #1;
      if (mrq_cs) begin
        mrs_ack = mem_en && (bcnt >= mem_lat);
        bcnt++;
      end else begin
        bcnt    = 0;
        mrs_ack = stray;
      end
    end
  end

  // ---------------- reference model ----------------
  // One open transaction at most; after it completes the port is closed for one cycle.
  bit     m_open = 1'b0;
  bit     m_gap  = 1'b0;
  int     m_last = NR - 1;
  int     m_wait = 0;
  bit     m_err  = 1'b0;
  logic [ADDR_WIDTH-1:0] m_addr = '0;
  logic   m_rw   = 1'b0;
  block_t m_data = '0;
  bit     m_found;
  int     m_idx;

  always @(posedge clk) begin
    if (rst) begin
      m_open = 1'b0; m_gap = 1'b0; m_last = NR - 1; m_wait = 0; m_err = 1'b0;
      m_addr = '0; m_rw = 1'b0; m_data = '0;
    end else if (m_open) begin
      if (mrs_ack) begin
        m_open = 1'b0;
        m_gap  = 1'b1;
      end else begin
        m_wait++;
        if (m_wait >= TO) m_err = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      m_found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        m_idx = (m_last + k) % NR;
        if (!m_found && rq_cs[m_idx]) begin
          m_found = 1'b1;
          m_last  = m_idx;
          m_addr  = rq_addr[m_idx];
          m_rw    = rq_rw[m_idx];
          m_data  = rq_data[m_idx];
          m_open  = 1'b1;
          m_wait  = 0;
        end
      end
    end
  end

  logic [NR-1:0] m_ack_exp;

  always @(negedge clk) begin
    if (chk_en) begin
      m_ack_exp = '0;
      if (m_open && mrs_ack) m_ack_exp[m_last] = 1'b1;
      check("mdl_mrq_cs",   mrq_cs,      m_open);
      check("mdl_busy",     busy,        m_open);
      check("mdl_mrq_addr", mrq_addr,    m_addr);
      check("mdl_mrq_rw",   mrq_rw,      m_rw);
      check("mdl_mrq_data", mrq_data,    m_data);
      check("mdl_gnt_id",   gnt_id,      m_last[0]);
      check("mdl_rs_ack",   rs_ack,      m_ack_exp);
      check("mdl_rs_data",  rs_data,     mrs_data);
      check("mdl_err",      err_timeout, m_err);
    end
  end

  // ---------------- directed scenarios ----------------
  int            n_cyc;
  bit            ok;
  int            exp_g[3] = '{0, 1, 0};
  logic [NR-1:0] ack_exp;

  initial begin
    rst     = 1'b1;
    rq_addr = '0;
    rq_cs   = '0;
    rq_rw   = '0;
    rq_data = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_mrq_cs",   mrq_cs,      1'b0);
    check("rst_busy",     busy,        1'b0);
    check("rst_gnt_id",   gnt_id,      1'b1);
    check("rst_rs_ack",   rs_ack,      2'b00);
    check("rst_err",      err_timeout, 1'b0);
    check("rst_mrq_addr", mrq_addr,    32'h0);

    // Single requester 1, read of 0x100
    rq_addr[1] = 32'h100;
    rq_rw[1]   = 1'b0;
    rq_data[1] = {32'h13, 32'h12, 32'h11, 32'h10};
    rq_cs[1]   = 1'b1;
    tick();
    check("t1_mrq_cs",   mrq_cs,   1'b1);
    check("t1_mrq_addr", mrq_addr, 32'h100);
    check("t1_gnt_id",   gnt_id,   1'b1);
    check("t1_mrq_data", mrq_data, {32'h13, 32'h12, 32'h11, 32'h10});
    // Requester changes its request mid-flight; the memory side must not follow.
    rq_addr[1] = 32'h200;
    rq_rw[1]   = 1'b1;
    tick();
    check("stab_addr", mrq_addr, 32'h100);
    check("stab_rw",   mrq_rw,   1'b0);
    // Ack is due 3 cycles after cs rose; we are already one cycle in.
    wait_ack(20, n_cyc, ok);
    check("t1_ack_seen",  ok,      1'b1);
    check("t1_ack_delay", n_cyc,   2);
    check("t1_rs_ack",    rs_ack,  2'b10);
    check("t1_rs_data",   rs_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check("t1_addr_held", mrq_addr, 32'h100);
    rq_cs[1]   = 1'b0;
    rq_addr[1] = 32'h100;
    rq_rw[1]   = 1'b0;
    tick();
    check("t1_release_cs", mrq_cs, 1'b0);
    tick();

    // Stray ack while idle
    stray = 1'b1;
    tick();
    check("stray_rs_ack", rs_ack, 2'b00);
    check("stray_busy",   busy,   1'b0);
    tick();
    check("stray_busy2",  busy,   1'b0);
    check("stray_gnt",    gnt_id, 1'b1);
    stray = 1'b0;
    tick();

    // Contention after reset: grants 0,1,0 with a cs-low gap
    pulse_reset();
    rq_addr[0] = 32'h300;
    rq_addr[1] = 32'h400;
    rq_cs      = 2'b11;
    tick();
    check("c_first_cs",   mrq_cs,   1'b1);
    check("c_first_gnt",  gnt_id,   1'b0);
    check("c_first_addr", mrq_addr, 32'h300);
    for (int g = 0; g < 3; g++) begin
      if (g > 0) begin
        tick();
        check("c_idle_cs", mrq_cs, 1'b0);
        tick();
        check("c_regrant_cs",  mrq_cs, 1'b1);
        check("c_regrant_gnt", gnt_id, exp_g[g][0]);
      end
      wait_ack(20, n_cyc, ok);
      check("c_ack_seen", ok, 1'b1);
      ack_exp = '0;
      ack_exp[exp_g[g]] = 1'b1;
      check("c_rs_ack", rs_ack, ack_exp);
      if (g == 2) rq_cs = 2'b00;
      tick();
      check("c_release_cs", mrq_cs, 1'b0);
    end
    tick();

    // Reset in the middle of a transaction granted to requester 1
    mem_en   = 1'b0;
    rq_cs[1] = 1'b1;
    tick();
    check("r_cs",  mrq_cs, 1'b1);
    check("r_gnt", gnt_id, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    rq_cs = 2'b11;
    check("r_cs_low",  mrq_cs, 1'b0);
    check("r_no_ack",  rs_ack, 2'b00);
    check("r_gnt_rst", gnt_id, 1'b1);
    tick();
    check("r_next_cs",  mrq_cs, 1'b1);
    check("r_next_gnt", gnt_id, 1'b0);
    mem_en = 1'b1;
    rq_cs  = 2'b00;
    wait_ack(20, n_cyc, ok);
    check("r_ack_seen", ok,     1'b1);
    check("r_rs_ack",   rs_ack, 2'b01);
    tick();
    tick();

    // Watchdog: memory silent for longer than TO cycles
    mem_en   = 1'b0;
    rq_cs[0] = 1'b1;
    tick();
    check("w_cs",   mrq_cs,      1'b1);
    check("w_err0", err_timeout, 1'b0);
    repeat (7) tick();
    check("w_err_b7", err_timeout, 1'b0);
    tick();
    check("w_err_b8", err_timeout, 1'b1);
    check("w_cs_b8",  mrq_cs,      1'b1);
    repeat (5) tick();
    check("w_err_hold", err_timeout, 1'b1);
    check("w_cs_hold",  mrq_cs,      1'b1);
    rq_cs  = 2'b00;
    mem_en = 1'b1;
    wait_ack(20, n_cyc, ok);
    check("w_ack_seen", ok,     1'b1);
    check("w_rs_ack",   rs_ack, 2'b01);
    tick();
    check("w_release_cs", mrq_cs,      1'b0);
    check("w_err_sticky", err_timeout, 1'b1);
    tick();
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
